// File: rtl/e203_icb_sram_slv.sv
// e203_icb_sram_slv: ICB target backed by a word-organised SRAM model.
// One outstanding transaction, optional wait states, error on window miss.
module e203_icb_sram_slv #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned       DEPTH_LOG2 = 10,
    parameter int unsigned       WAIT_CYC   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ADDR_W-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [31:0]       icb_cmd_wdata,
    input  logic [3:0]        icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic              icb_rsp_err,
    output logic [31:0]       icb_rsp_rdata
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam bit          HAS_WAIT = (WAIT_CYC != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             mem_q [DEPTH];

    logic                    cmd_hs;
    logic                    hit;
    logic                    wr_en;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    addr_unused;

    // Window is aligned, so a hit is a compare of the bits above the word index.
    assign hit = icb_cmd_addr[ADDR_W-1:DEPTH_LOG2+2]
                 == BASE_ADDR[ADDR_W-1:DEPTH_LOG2+2];
    assign idx = icb_cmd_addr[DEPTH_LOG2+1:2];
    assign addr_unused = ^icb_cmd_addr[1:0];

    always_comb begin
        icb_cmd_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: icb_cmd_ready = 1'b1;
            ST_WAIT: icb_cmd_ready = 1'b0;
            ST_RESP: icb_cmd_ready = !HAS_WAIT && icb_rsp_ready;
            default: icb_cmd_ready = 1'b0;
        endcase
    end

    assign cmd_hs = icb_cmd_valid && icb_cmd_ready;
    assign wr_en  = cmd_hs && !icb_cmd_read && hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rdata_d     = rdata_q;
        if (cmd_hs) begin
            rsp_err_d = !hit;
            rdata_d   = (icb_cmd_read && hit) ? mem_q[idx] : 32'h0;
            if (HAS_WAIT) begin
                state_d     = ST_WAIT;
                cnt_d       = 4'(WAIT_CYC - 1);
                rsp_valid_d = 1'b0;
            end else begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (icb_rsp_ready) begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage survives reset, so it sits outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (icb_cmd_wmask[b]) begin
                    mem_q[idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_err   = rsp_err_q;
    assign icb_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_e203_icb_sram_slv.sv
// tb_e203_icb_sram_slv: two targets (no wait / 3 wait states) checked
// against a transaction-level model plus hand-computed directed vectors.
module tb_e203_icb_sram_slv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cv [2];
    logic        cr [2];
    logic        rd [2];
    logic [31:0] ca [2];
    logic [31:0] wd [2];
    logic [3:0]  wm [2];
    logic        rv [2];
    logic        rr [2];
    logic        re [2];
    logic [31:0] rdat [2];

    e203_icb_sram_slv #(.WAIT_CYC(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(cv[0]), .icb_cmd_ready(cr[0]),
        .icb_cmd_addr(ca[0]), .icb_cmd_read(rd[0]),
        .icb_cmd_wdata(wd[0]), .icb_cmd_wmask(wm[0]),
        .icb_rsp_valid(rv[0]), .icb_rsp_ready(rr[0]),
        .icb_rsp_err(re[0]), .icb_rsp_rdata(rdat[0])
    );

    e203_icb_sram_slv #(.WAIT_CYC(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(cv[1]), .icb_cmd_ready(cr[1]),
        .icb_cmd_addr(ca[1]), .icb_cmd_read(rd[1]),
        .icb_cmd_wdata(wd[1]), .icb_cmd_wmask(wm[1]),
        .icb_rsp_valid(rv[1]), .icb_rsp_ready(rr[1]),
        .icb_rsp_err(re[1]), .icb_rsp_rdata(rdat[1])
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)",
                     nm, d, act, exp, $time);
        end
    endtask

    // Model: window 0x8000_0000..0x8000_0FFF, one pending response per target,
    // response visible 1+W cycles after the accepting edge.
    logic [31:0] mm [2][1024];
    bit          kn [2][1024];
    bit          pend [2];
    int          acc [2];
    logic        perr [2];
    logic [31:0] prd [2];
    bit          pknown [2];
    int          w_m;
    int          idx_m;
    bit          ev_m;
    bit          ecr_m;
    bit          hit_m;

    initial begin
        pend[0] = 0;
        pend[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) kn[d][i] = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pend[0] = 0;
            pend[1] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                w_m   = (d == 0) ? 0 : 3;
                ev_m  = pend[d] && (cyc - acc[d] >= 1 + w_m);
                ecr_m = !pend[d] || (w_m == 0 && ev_m && rr[d]);
                chk("rsp_valid", d, 32'(rv[d]), 32'(ev_m));
                chk("cmd_ready", d, 32'(cr[d]), 32'(ecr_m));
                if (ev_m) begin
                    chk("rsp_err", d, 32'(re[d]), 32'(perr[d]));
                    if (pknown[d]) chk("rsp_rdata", d, rdat[d], prd[d]);
                end
                if (ev_m && rr[d]) pend[d] = 0;
                if (cv[d] && ecr_m) begin
                    hit_m = ca[d] >= 32'h8000_0000 && ca[d] < 32'h8000_1000;
                    idx_m = int'((ca[d] - 32'h8000_0000) / 4);
                    pend[d]   = 1;
                    acc[d]    = cyc;
                    perr[d]   = !hit_m;
                    prd[d]    = 32'h0;
                    pknown[d] = 1;
                    if (hit_m && rd[d]) begin
                        prd[d]    = mm[d][idx_m];
                        pknown[d] = kn[d][idx_m];
                    end
                    if (hit_m && !rd[d]) begin
                        for (int b = 0; b < 4; b++)
                            if (wm[d][b]) mm[d][idx_m][8*b +: 8] = wd[d][8*b +: 8];
                        if (wm[d] == 4'hF) kn[d][idx_m] = 1;
                    end
                end
            end
        end
    end

    task automatic cmd(input int d, input bit r, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] m);
        int n = 0;
        cv[d] = 1; rd[d] = r; ca[d] = a; wd[d] = w; wm[d] = m;
        do begin
            @(negedge clk);
            n++;
        end while (!cr[d] && n < 50);
        if (!cr[d]) begin
            checks++;
            failures++;
            $display("FAIL cmd_timeout dut%0d: cmd_ready got 0 expected 1", d);
        end
        @(posedge clk);
        #1 cv[d] = 0;
    endtask

    task automatic wait_rsp(input int d, output logic err,
                            output logic [31:0] data, output int lat,
                            output bit crlow);
        lat = 0;
        crlow = 1;
        do begin
            @(negedge clk);
            lat++;
            if (cr[d]) crlow = 0;
        end while (!rv[d] && lat < 50);
        if (!rv[d]) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout dut%0d: rsp_valid got 0 expected 1", d);
        end
        err = re[d];
        data = rdat[d];
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int d, input bit r, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] m,
                        output logic err, output logic [31:0] data,
                        output int lat);
        bit crl;
        cmd(d, r, a, w, m);
        wait_rsp(d, err, data, lat, crl);
    endtask

    logic        e;
    logic [31:0] q;
    int          lat;
    bit          crl;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            cv[d] = 0; rd[d] = 0; ca[d] = 0; wd[d] = 0; wm[d] = 0; rr[d] = 1;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_rsp_valid", d, 32'(rv[d]), 32'h0);
            chk("reset_cmd_ready", d, 32'(cr[d]), 32'h1);
            chk("reset_rdata", d, rdat[d], 32'h0);
            chk("reset_err", d, 32'(re[d]), 32'h0);
        end
        @(posedge clk);
        #1;

        // masked write merge
        xfer(0, 0, 32'h8000_0010, 32'h1122_3344, 4'hF, e, q, lat);
        chk("wr_err", 0, 32'(e), 32'h0);
        chk("wr_rdata", 0, q, 32'h0);
        chk("wr_lat", 0, 32'(lat), 32'd1);
        xfer(0, 0, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0101, e, q, lat);
        xfer(0, 1, 32'h8000_0010, 32'h0, 4'h0, e, q, lat);
        chk("mask_rdata", 0, q, 32'h11AD_33EF);
        chk("mask_err", 0, 32'(e), 32'h0);

        // window edges
        xfer(0, 0, 32'h8000_0000, 32'hA5A5_0001, 4'hF, e, q, lat);
        xfer(0, 1, 32'h8000_1000, 32'h0, 4'h0, e, q, lat);
        chk("oow_rd_err", 0, 32'(e), 32'h1);
        chk("oow_rd_rdata", 0, q, 32'h0);
        xfer(0, 0, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, e, q, lat);
        chk("oow_wr_err", 0, 32'(e), 32'h1);
        xfer(0, 1, 32'h8000_0000, 32'h0, 4'h0, e, q, lat);
        chk("no_wrap", 0, q, 32'hA5A5_0001);
        xfer(0, 0, 32'h8000_0FFC, 32'hCAFE_0FFC, 4'hF, e, q, lat);
        xfer(0, 1, 32'h8000_0FFC, 32'h0, 4'h0, e, q, lat);
        chk("top_rdata", 0, q, 32'hCAFE_0FFC);
        chk("top_err", 0, 32'(e), 32'h0);
        xfer(0, 1, 32'h7FFF_FFFC, 32'h0, 4'h0, e, q, lat);
        chk("below_err", 0, 32'(e), 32'h1);
        xfer(0, 0, 32'h8000_0000, 32'h0BAD_0BAD, 4'h0, e, q, lat);
        chk("mask0_err", 0, 32'(e), 32'h0);
        xfer(0, 1, 32'h8000_0000, 32'h0, 4'h0, e, q, lat);
        chk("mask0_keep", 0, q, 32'hA5A5_0001);

        // wait states
        xfer(1, 0, 32'h8000_0020, 32'h1234_5678, 4'hF, e, q, lat);
        chk("w3_wr_lat", 1, 32'(lat), 32'd4);
        cmd(1, 1, 32'h8000_0020, 32'h0, 4'h0);
        wait_rsp(1, e, q, lat, crl);
        chk("w3_rd_lat", 1, 32'(lat), 32'd4);
        chk("w3_cmd_ready_low", 1, 32'(crl), 32'h1);
        chk("w3_rd_rdata", 1, q, 32'h1234_5678);

        // back-to-back reads
        for (int i = 0; i < 8; i++)
            xfer(0, 0, 32'h8000_0100 + 32'(4 * i), 32'h5000_0000 + 32'(i * 17),
                 4'hF, e, q, lat);
        cv[0] = 1;
        rd[0] = 1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) ca[0] = 32'h8000_0100 + 32'(4 * i);
            else cv[0] = 0;
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_valid", 0, 32'(rv[0]), 32'h1);
                chk("b2b_rdata", 0, rdat[0], 32'h5000_0000 + 32'((i - 1) * 17));
            end
            if (i < 8) chk("b2b_cmd_ready", 0, 32'(cr[0]), 32'h1);
            @(posedge clk);
            #1;
        end

        // back-pressure: rsp held, new cmd ignored
        rr[0] = 0;
        cmd(0, 1, 32'h8000_0010, 32'h0, 4'h0);
        cv[0] = 1; rd[0] = 0; ca[0] = 32'h8000_0010;
        wd[0] = 32'h0; wm[0] = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 0, 32'(rv[0]), 32'h1);
            chk("hold_rdata", 0, rdat[0], 32'h11AD_33EF);
            chk("hold_cmd_ready", 0, 32'(cr[0]), 32'h0);
        end
        @(posedge clk);
        #1 cv[0] = 0;
        rr[0] = 1;
        @(posedge clk);
        #1;
        xfer(0, 1, 32'h8000_0010, 32'h0, 4'h0, e, q, lat);
        chk("hold_no_write", 0, q, 32'h11AD_33EF);

        // reset with a pending response
        rr[0] = 0;
        cmd(0, 0, 32'h8000_0030, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        chk("pre_reset_valid", 0, 32'(rv[0]), 32'h1);
        @(posedge clk);
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        rr[0] = 1;
        @(negedge clk);
        chk("rst_rsp_valid", 0, 32'(rv[0]), 32'h0);
        chk("rst_rdata", 0, rdat[0], 32'h0);
        chk("rst_cmd_ready", 0, 32'(cr[0]), 32'h1);
        @(posedge clk);
        #1;
        xfer(0, 1, 32'h8000_0030, 32'h0, 4'h0, e, q, lat);
        chk("rst_write_kept", 0, q, 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
